// File: rtl/sensor_arbiter_pkg.sv
// rtl/sensor_arbiter_pkg.sv - shared defaults and helpers for the sensor arbiter slice
package sensor_arbiter_pkg;

  localparam int DEF_NUM_SENSORS = 16;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ID_WIDTH    = 6;
  localparam int DEF_OVR_WIDTH   = 16;
  localparam int MAX_SENSORS     = 64;

  function automatic logic [6:0] popcount(input logic [MAX_SENSORS-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < MAX_SENSORS; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter owning the rotating search pointer
module rr_arbiter #(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         request,
  input  logic                 enable,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid
);

  localparam int W = $clog2(N);

  // Holds last_grant+1 so that reset to 0 makes channel 0 the first to be searched.
  logic [W-1:0] next_ptr;
  int           c;
  logic [W-1:0] cw;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    c           = 0;
    cw          = '0;
    if (enable) begin
      for (int i = 0; i < N; i++) begin
        c = int'(next_ptr) + i;
        if (c >= N) c = c - N;
        cw = W'(c);
        if (!grant_valid && request[cw]) begin
          grant_valid = 1'b1;
          grant_idx   = cw;
          grant[cw]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_ptr <= '0;
    end else if (grant_valid) begin
      next_ptr <= (grant_idx == W'(N-1)) ? '0 : grant_idx + W'(1);
    end
  end

endmodule

// File: rtl/sensor_arbiter.sv
// rtl/sensor_arbiter.sv - per-channel pending capture serialised onto one tagged output stream
module sensor_arbiter
  import sensor_arbiter_pkg::*;
#(
  parameter int NUM_SENSORS = DEF_NUM_SENSORS,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ID_WIDTH    = DEF_ID_WIDTH,
  parameter int OVR_WIDTH   = DEF_OVR_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_SENSORS*DATA_WIDTH-1:0] sensor_values,
  input  logic [NUM_SENSORS-1:0]            data_available,
  input  logic                              ready,
  output logic [DATA_WIDTH-1:0]             sensor_value_out,
  output logic [ID_WIDTH-1:0]               sensor_id_out,
  output logic                              write,
  output logic [OVR_WIDTH-1:0]              overrun_count,
  input  logic                              clear_overrun
);

  localparam int SW = $clog2(NUM_SENSORS);

  logic [DATA_WIDTH-1:0]  hold [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] pending;
  logic [NUM_SENSORS-1:0] grant;
  logic [NUM_SENSORS-1:0] overrun_mask;
  logic [SW-1:0]          grant_idx;
  logic                   grant_valid;
  logic                   out_free;
  logic [6:0]             overrun_inc;
  logic [OVR_WIDTH:0]     overrun_sum;

  assign out_free = !write || ready;

  // A strobe on the channel being granted this cycle is a refill, not an overrun.
  assign overrun_mask = data_available & pending & ~grant;
  assign overrun_inc  = popcount(MAX_SENSORS'(overrun_mask));
  assign overrun_sum  = {1'b0, overrun_count} + (OVR_WIDTH+1)'(overrun_inc);

  rr_arbiter #(
    .N(NUM_SENSORS)
  ) u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .request     (pending),
    .enable      (out_free),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_SENSORS; k++) hold[k] <= '0;
      pending          <= '0;
      write            <= 1'b0;
      sensor_value_out <= '0;
      sensor_id_out    <= '0;
      overrun_count    <= '0;
    end else begin
      pending <= (pending & ~grant) | data_available;
      for (int k = 0; k < NUM_SENSORS; k++) begin
        if (data_available[k]) hold[k] <= sensor_values[k*DATA_WIDTH +: DATA_WIDTH];
      end

      if (out_free) begin
        if (grant_valid) begin
          sensor_value_out <= hold[grant_idx];
          sensor_id_out    <= ID_WIDTH'(grant_idx);
          write            <= 1'b1;
        end else begin
          write <= 1'b0;
        end
      end

      if (clear_overrun) begin
        overrun_count <= '0;
      end else if (overrun_sum[OVR_WIDTH]) begin
        overrun_count <= '1;
      end else begin
        overrun_count <= overrun_sum[OVR_WIDTH-1:0];
      end
    end
  end

endmodule
